// File: rtl/sv_mem_ctrl.sv
// Survivor-path SRAM controller: arbitrates ACS writes against traceback reads onto one registered SRAM port.
// Read data returns 2 edges after accept; the write stream is held off after WR_BURST_MAX grants while a read waits.
module sv_mem_ctrl #(
  parameter int DW           = 24,
  parameter int AW           = 11,
  parameter int WR_BURST_MAX = 4
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          wr_valid_i,
  input  logic [DW-1:0] wr_data_i,
  output logic          wr_ready_o,
  output logic [AW-1:0] wr_ptr_o,
  output logic          wr_wrap_o,
  input  logic          wptr_clr_i,
  input  logic          rd_req_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic          rd_ack_o,
  output logic          rd_valid_o,
  output logic [DW-1:0] rd_data_o,
  output logic          sram_wr_en_o,
  output logic          sram_rd_en_o,
  output logic [AW-1:0] sram_addr_o,
  output logic [DW-1:0] sram_wdata_o,
  input  logic [DW-1:0] sram_rdata_i
);

  localparam int SW = $clog2(WR_BURST_MAX + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(WR_BURST_MAX);

  logic [SW-1:0] streak;
  logic [1:0]    rd_tag;
  logic          rd_turn;
  logic          wr_grant;
  logic          rd_grant;

  // Once the writer has won WR_BURST_MAX times in a row against a waiting read, the read takes the port.
  assign rd_turn    = (streak == STREAK_MAX);
  assign rd_grant   = rd_req_i && (wptr_clr_i || !wr_valid_i || rd_turn);
  assign wr_grant   = wr_valid_i && !wptr_clr_i && !(rd_req_i && rd_turn);
  assign wr_ready_o = wr_grant;
  assign rd_ack_o   = rd_grant;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_o     <= '0;
      wr_wrap_o    <= 1'b0;
      rd_valid_o   <= 1'b0;
      rd_data_o    <= '0;
      sram_wr_en_o <= 1'b0;
      sram_rd_en_o <= 1'b0;
      sram_addr_o  <= '0;
      sram_wdata_o <= '0;
      streak       <= '0;
      rd_tag       <= '0;
    end else begin
      sram_wr_en_o <= wr_grant;
      sram_rd_en_o <= rd_grant;
      wr_wrap_o    <= wr_grant && (wr_ptr_o == {AW{1'b1}});

      if (wr_grant) begin
        sram_addr_o  <= wr_ptr_o;
        sram_wdata_o <= wr_data_i;
      end else if (rd_grant) begin
        sram_addr_o  <= rd_addr_i;
      end

      if (wptr_clr_i) begin
        wr_ptr_o <= '0;
      end else if (wr_grant) begin
        wr_ptr_o <= wr_ptr_o + 1'b1;
      end

      if (wptr_clr_i || rd_grant || !rd_req_i) begin
        streak <= '0;
      end else if (wr_grant && streak != STREAK_MAX) begin
        streak <= streak + 1'b1;
      end

      // The SRAM bus floats when idle, so data is captured only on a tagged return cycle.
      rd_tag     <= {rd_tag[0], rd_grant};
      rd_valid_o <= rd_tag[1];
      if (rd_tag[1]) begin
        rd_data_o <= sram_rdata_i;
      end
    end
  end

endmodule

// File: tb/tb_sv_mem_ctrl.sv
// Scoreboard bench for sv_mem_ctrl with a behavioural SRAM and arbitration/memory reference model.
module tb_sv_mem_ctrl;
  localparam int DW = 24;
  localparam int AW = 11;
  localparam int BM = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk, rst_n;
  logic          wr_valid, wptr_clr, rd_req;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] rd_addr;
  logic          wr_ready, wr_wrap, rd_ack, rd_valid;
  logic [AW-1:0] wr_ptr, sram_addr;
  logic [DW-1:0] rd_data, sram_wdata, sram_rdata;
  logic          sram_wr_en, sram_rd_en;

  sv_mem_ctrl #(.DW(DW), .AW(AW), .WR_BURST_MAX(BM)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .wr_valid_i(wr_valid), .wr_data_i(wr_data), .wr_ready_o(wr_ready),
    .wr_ptr_o(wr_ptr), .wr_wrap_o(wr_wrap), .wptr_clr_i(wptr_clr),
    .rd_req_i(rd_req), .rd_addr_i(rd_addr), .rd_ack_o(rd_ack),
    .rd_valid_o(rd_valid), .rd_data_o(rd_data),
    .sram_wr_en_o(sram_wr_en), .sram_rd_en_o(sram_rd_en),
    .sram_addr_o(sram_addr), .sram_wdata_o(sram_wdata), .sram_rdata_i(sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural SRAM: registered read, junk on the bus when not reading.
  logic [DW-1:0] smem [DEPTH];
  always @(posedge clk) begin
    if (sram_wr_en) smem[sram_addr] <= sram_wdata;
    if (sram_rd_en) sram_rdata <= smem[sram_addr];
    else            sram_rdata <= DW'($urandom);
  end

  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; int t; } ent_t;
  ent_t wq[$], raq[$], rdq[$];
  int   wrapq[$];

  logic [DW-1:0] m_mem [DEPTH];
  int m_ptr, wins, pend;
  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic unexp(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: output seen with nothing expected (cycle %0d)", nm, cyc);
  endtask

  // Drive one cycle, predict the grant, log expected SRAM commands and returns.
  task automatic step(input logic wv, input logic [DW-1:0] wd, input logic clr,
                      input logic rq, input logic [AW-1:0] ra);
    logic er, ew;
    ent_t e;
    wr_valid = wv; wr_data = wd; wptr_clr = clr; rd_req = rq; rd_addr = ra;
    #1;
    er = rq && (clr || !wv || wins >= BM);
    ew = wv && !clr && !er;
    chk("wr_ready", wr_ready, ew);
    chk("rd_ack", rd_ack, er);
    if (er) begin
      chk("rd_wait_bound", (pend + 1 <= BM + 1), 1);
      e.a = ra; e.d = m_mem[ra]; e.t = cyc + 1; raq.push_back(e);
      e.t = cyc + 3; rdq.push_back(e);
    end
    if (ew) begin
      e.a = AW'(m_ptr); e.d = wd; e.t = cyc + 1; wq.push_back(e);
      if (m_ptr == DEPTH - 1) wrapq.push_back(cyc + 1);
      m_mem[m_ptr] = wd;
      m_ptr = (m_ptr + 1) % DEPTH;
    end
    if (clr) m_ptr = 0;
    if (er || !rq || clr) wins = 0;
    else if (ew) wins++;
    pend = (rq && !er) ? pend + 1 : 0;
    @(posedge clk); #1;
  endtask

  task automatic model_reset();
    wq.delete(); raq.delete(); rdq.delete(); wrapq.delete();
    m_ptr = 0; wins = 0; pend = 0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_wr_ptr"}, wr_ptr, 0);
    chk({tag, "_wr_wrap"}, wr_wrap, 0);
    chk({tag, "_rd_valid"}, rd_valid, 0);
    chk({tag, "_rd_data"}, rd_data, 0);
    chk({tag, "_sram_wr_en"}, sram_wr_en, 0);
    chk({tag, "_sram_rd_en"}, sram_rd_en, 0);
    chk({tag, "_sram_addr"}, sram_addr, 0);
    chk({tag, "_sram_wdata"}, sram_wdata, 0);
  endtask

  always @(negedge clk) begin
    ent_t e;
    if (rst_n) begin
      chk("one_cmd", sram_wr_en & sram_rd_en, 0);
      if (sram_wr_en) begin
        if (wq.size() == 0) unexp("sram_wr");
        else begin
          e = wq.pop_front();
          chk("sram_wr_addr", sram_addr, e.a);
          chk("sram_wr_data", sram_wdata, e.d);
          chk("sram_wr_cycle", cyc, e.t);
        end
      end
      if (sram_rd_en) begin
        if (raq.size() == 0) unexp("sram_rd");
        else begin
          e = raq.pop_front();
          chk("sram_rd_addr", sram_addr, e.a);
          chk("sram_rd_cycle", cyc, e.t);
        end
      end
      if (rd_valid) begin
        if (rdq.size() == 0) unexp("rd_valid");
        else begin
          e = rdq.pop_front();
          chk("rd_data", rd_data, e.d);
          chk("rd_valid_cycle", cyc, e.t);
        end
      end
      if (wr_wrap) begin
        if (wrapq.size() == 0) unexp("wr_wrap");
        else chk("wr_wrap_cycle", cyc, wrapq.pop_front());
      end
    end
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      smem[i] = '0;
      m_mem[i] = '0;
    end
    model_reset();
    rst_n = 1'b0; wr_valid = 0; wr_data = '0; wptr_clr = 0; rd_req = 0; rd_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("rst");
    rst_n = 1'b1;

    // Single write
    step(1, 24'hA5A5A5, 0, 0, 0);
    chk("w1_en", sram_wr_en, 1);
    chk("w1_addr", sram_addr, 0);
    chk("w1_data", sram_wdata, 24'hA5A5A5);
    chk("w1_ptr", wr_ptr, 1);

    // Write then read at address 0
    step(0, 0, 1, 0, 0);
    step(1, 24'h123456, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    chk("wr_rd_rden", sram_rd_en, 1);
    chk("wr_rd_addr", sram_addr, 0);
    step(0, 0, 0, 0, 0);
    chk("wr_rd_early", rd_valid, 0);
    step(0, 0, 0, 0, 0);
    chk("wr_rd_valid", rd_valid, 1);
    chk("wr_rd_data", rd_data, 24'h123456);
    step(0, 0, 0, 0, 0);
    chk("wr_rd_single", rd_valid, 0);

    // Wrap over the full depth
    step(0, 0, 1, 0, 0);
    for (int i = 0; i < DEPTH + 1; i++) step(1, DW'($urandom), 0, 0, 0);
    chk("wrap_ptr", wr_ptr, 1);
    step(0, 0, 0, 0, 0);
    chk("wrap_seen", wrapq.size(), 0);

    // Continuous writes against a continuous read request
    for (int i = 0; i < 30; i++) step(1, DW'($urandom), 0, 1, AW'($urandom));
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0);

    // Pointer clear while a write is offered
    step(0, 0, 1, 0, 0);
    for (int i = 0; i < 37; i++) step(1, DW'($urandom), 0, 0, 0);
    chk("clr_ptr37", wr_ptr, 37);
    step(1, 24'h777777, 1, 0, 0);
    chk("clr_ptr0", wr_ptr, 0);
    step(1, 24'h0C0FFE, 0, 0, 0);
    chk("clr_next_addr", sram_addr, 0);

    // Random traffic, reads aimed near the write pointer to hit adjacent read/write pairs
    for (int i = 0; i < 3000; i++)
      step(($urandom % 4) != 0, DW'($urandom), ($urandom % 64) == 0,
           ($urandom % 3) == 0, AW'(m_ptr - int'($urandom_range(0, 3))));
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0);
    chk("drain_wq", wq.size(), 0);
    chk("drain_raq", raq.size(), 0);
    chk("drain_rdq", rdq.size(), 0);
    chk("drain_wrapq", wrapq.size(), 0);

    // Reset while a read is in flight
    step(0, 0, 0, 1, AW'(5));
    rst_n = 1'b0;
    rd_req = 0;
    #1;
    chk_reset_outputs("midrst");
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("midrst_no_valid", rd_valid, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sv_mem_ctrl.md
# sv_mem_ctrl

Controller and arbiter for the Viterbi decoder's single-port 24x2048 survivor-path SRAM. It shares the one SRAM port between two requesters. The ACS write stream stores one 24-bit survivor-decision word per trellis step at an auto-incrementing circular address. The traceback unit reads arbitrary addresses. The block registers all SRAM commands, pipelines read data back with a fixed latency, and bounds read starvation under continuous writes.

## Interface
Parameters:
- DW, 24, data width (SRAM word)
- AW, 11, address width (depth 2^AW = 2048)
- WR_BURST_MAX, 4, maximum consecutive write grants while a read is pending

Ports:
- clk_i  in  1  clock, all logic on rising edge
- rst_n_i  in  1  reset, asynchronous, active-low
- wr_valid_i  in  1  ACS survivor word available
- wr_data_i  in  DW  survivor word
- wr_ready_o  out  1  write grant this cycle (combinational); transfer on valid&ready at rising edge
- wr_ptr_o  out  AW  address the next accepted write will use
- wr_wrap_o  out  1  one-cycle pulse after a write to address 2^AW-1 is accepted
- wptr_clr_i  in  1  synchronous clear of write pointer (frame start)
- rd_req_i  in  1  traceback read request
- rd_addr_i  in  AW  traceback read address
- rd_ack_o  out  1  read grant this cycle (combinational); transfer on req&ack at rising edge
- rd_valid_o  out  1  one-cycle pulse: rd_data_o holds returned word
- rd_data_o  out  DW  returned read data, registered
- sram_wr_en_o  out  1  SRAM write enable, registered
- sram_rd_en_o  out  1  SRAM read enable, registered
- sram_addr_o  out  AW  SRAM address, registered
- sram_wdata_o  out  DW  SRAM write data, registered
- sram_rdata_i  in  DW  SRAM read data, registered inside SRAM, high-Z when SRAM idle

## Operation
- One grant per cycle at most; wr_ready_o and rd_ack_o never high together.
- wptr_clr_i=1 forces wr_ready_o=0. At the edge, wr_ptr_o<=0 and streak<=0. Reads are still arbitrable in that cycle.
- Arbitration (wptr_clr_i=0):
  - Only wr_valid_i high: grant write.
  - Only rd_req_i high: grant read.
  - Both high: grant read if streak==WR_BURST_MAX, else grant write.
- Streak counter (0..WR_BURST_MAX):
  - Increments on a write grant while rd_req_i=1, saturating.
  - Clears on a read grant or on any cycle with rd_req_i=0.
- Accepted write: sram_wr_en_o<=1, sram_addr_o<=wr_ptr_o, sram_wdata_o<=wr_data_i, wr_ptr_o<=wr_ptr_o+1 mod 2^AW. wr_wrap_o<=1 when the old wr_ptr_o was 2^AW-1.
- Accepted read: sram_rd_en_o<=1, sram_addr_o<=rd_addr_i, and a 2-stage read-tag pipeline is set.
- No grant: both enables <=0. sram_addr_o and sram_wdata_o hold their last values.
- rd_data_o loads only when the read tag reaches stage 2. sram_rdata_i is never sampled otherwise, because it is high-Z when the SRAM is idle. rd_data_o holds between reads.
- Reads and writes to the same address in adjacent cycles execute in grant order; no forwarding.

## Timing
- Reset (rst_n_i=0, async): wr_ptr_o=0, wr_wrap_o=0, rd_valid_o=0, rd_data_o=0, sram_wr_en_o=0, sram_rd_en_o=0, sram_addr_o=0, sram_wdata_o=0, streak=0, read pipeline cleared.
- Reset mid-read discards the in-flight read; rd_valid_o stays 0 after release.
- Write, accepted at edge E0: SRAM enable and address valid in cycle E0..E1; the SRAM writes at E1.
- Read, accepted at edge E0:
  - sram_rd_en_o high in cycle E0..E1; the SRAM registers data at E1.
  - The block captures it at E2; rd_valid_o is high in cycle E2..E3.
  - Latency is fixed at 2 edges.
  - Back-to-back reads give back-to-back rd_valid_o pulses at full throughput.
- Worst case under continuous writes: a pending read is granted within WR_BURST_MAX+1 cycles of rd_req_i rising.
- wr_ready_o and rd_ack_o depend combinationally on wr_valid_i, rd_req_i, wptr_clr_i and the streak register only.

## Test plan
- Reset then single write: wr_data_i=0xA5A5A5 with wr_valid_i pulse. Required: sram_wr_en_o=1, sram_addr_o=0, sram_wdata_o=0xA5A5A5 next cycle; wr_ptr_o=1.
- Write-then-read: write 0x123456 at address 0, then read rd_addr_i=0. Required: rd_ack_o=1 and sram_rd_en_o=1 next cycle; rd_valid_o=1, rd_data_o=0x123456 two edges after accept; no other rd_valid_o pulses.
- Wrap: 2049 continuous writes. Required: wr_wrap_o pulses once after the 2048th accept; the 2049th write goes to sram_addr_o=0; wr_ptr_o=1.
- Starvation bound: wr_valid_i and rd_req_i held high. Required: grant pattern is 4 writes then 1 read, repeating; rd_valid_o is 2 edges after each rd_ack_o.
- Clear: wptr_clr_i=1 for one cycle with wr_valid_i=1 and wr_ptr_o=37. Required: wr_ready_o=0 that cycle; wr_ptr_o=0 next cycle; the next write goes to address 0.
- Reset mid-read: assert rst_n_i=0 one cycle after rd_ack_o. Required: all outputs at reset values immediately; no rd_valid_o after release.
